// File: rtl/trng_ht_pkg.sv
// Shared types and width helpers for the TRNG continuous health-test slice.
package trng_ht_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAILED  = 2'd2
  } ht_state_e;

  // Bits needed to hold any count in 0..max_val.
  function automatic int unsigned ht_cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trng_ht_apt_window.sv
// Adaptive Proportion Test window: counts samples and reference-symbol matches
// per window and flags when the match count reaches the cutoff.
module trng_ht_apt_window
  import trng_ht_pkg::*;
#(
  parameter int unsigned SYM_W      = 1,
  parameter int unsigned APT_WINDOW = 1024,
  parameter int unsigned APT_CUTOFF = 589
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_accept,
  input  logic [SYM_W-1:0] i_sample,
  output logic             o_hit
);

  localparam int unsigned AW = ht_cnt_w(APT_WINDOW);

  logic             r_open;
  logic [SYM_W-1:0] r_ref;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    r_match;

  logic [AW-1:0]    w_cnt_next;
  logic [AW-1:0]    w_match_next;

  always_comb begin
    w_cnt_next   = r_cnt;
    w_match_next = r_match;
    if (!r_open) begin
      w_cnt_next   = AW'(1);
      w_match_next = AW'(1);
    end else begin
      w_cnt_next = r_cnt + AW'(1);
      if (i_sample == r_ref) begin
        w_match_next = r_match + AW'(1);
      end
    end
  end

  assign o_hit = i_accept && (w_match_next >= AW'(APT_CUTOFF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_open  <= 1'b0;
      r_ref   <= '0;
      r_cnt   <= '0;
      r_match <= '0;
    end else if (i_clr) begin
      r_open  <= 1'b0;
      r_ref   <= '0;
      r_cnt   <= '0;
      r_match <= '0;
    end else if (i_accept) begin
      r_cnt   <= w_cnt_next;
      r_match <= w_match_next;
      if (!r_open) begin
        r_ref <= i_sample;
      end
      // Window closes once the APT_WINDOW-th sample has been counted.
      r_open <= (w_cnt_next != AW'(APT_WINDOW));
    end
  end

endmodule

// File: rtl/trng_health_monitor.sv
// SP 800-90B continuous health monitor (RCT + APT) with startup/run/failed gating.
// Optional HT_STATS_EN adds the longest-run statistic on max_run.
module trng_health_monitor
  import trng_ht_pkg::*;
#(
  parameter int unsigned SYM_W           = 1,
  parameter int unsigned RCT_CUTOFF      = 10,
  parameter int unsigned APT_WINDOW      = 1024,
  parameter int unsigned APT_CUTOFF      = 589,
  parameter int unsigned STARTUP_SAMPLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             fail_clr,
  output logic             rct_fail,
  output logic             apt_fail,
  output logic             health_ok,
  output logic             startup_done,
  output logic [7:0]       max_run
);

  localparam int unsigned RW = ht_cnt_w(RCT_CUTOFF);
  localparam int unsigned SW = ht_cnt_w(STARTUP_SAMPLES);

  ht_state_e        r_state;
  ht_state_e        w_state_next;

  logic [RW-1:0]    r_run;
  logic [SYM_W-1:0] r_rct_ref;
  logic             r_have_ref;
  logic [SW-1:0]    r_su_cnt;
  logic             r_rct_fail;
  logic             r_apt_fail;
  logic             r_startup_done;

  logic             w_accept;
  logic [RW-1:0]    w_run_next;
  logic             w_rct_hit;
  logic             w_apt_hit;
  logic             w_alarm;
  logic [SW-1:0]    w_su_next;

  // A clear in the same cycle as a sample discards that sample.
  assign w_accept = sample_valid && !fail_clr && (r_state != ST_FAILED);

  always_comb begin
    w_run_next = RW'(1);
    if (r_have_ref && (sample_in == r_rct_ref)) begin
      w_run_next = (r_run == '1) ? r_run : r_run + RW'(1);
    end
  end

  assign w_rct_hit = w_accept && (w_run_next >= RW'(RCT_CUTOFF));
  assign w_alarm   = w_rct_hit || w_apt_hit;
  assign w_su_next = r_su_cnt + SW'(1);

  trng_ht_apt_window #(
    .SYM_W      (SYM_W),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_apt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (fail_clr),
    .i_accept (w_accept),
    .i_sample (sample_in),
    .o_hit    (w_apt_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_STARTUP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (fail_clr) begin
      w_state_next = ST_STARTUP;
    end else begin
      unique case (r_state)
        ST_STARTUP: begin
          if (w_accept) begin
            if (w_alarm) begin
              w_state_next = ST_FAILED;
            end else if (w_su_next == SW'(STARTUP_SAMPLES)) begin
              w_state_next = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_alarm) begin
            w_state_next = ST_FAILED;
          end
        end
        ST_FAILED: w_state_next = ST_FAILED;
        default:   w_state_next = ST_STARTUP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run          <= '0;
      r_rct_ref      <= '0;
      r_have_ref     <= 1'b0;
      r_su_cnt       <= '0;
      r_rct_fail     <= 1'b0;
      r_apt_fail     <= 1'b0;
      r_startup_done <= 1'b0;
    end else if (fail_clr) begin
      r_run          <= '0;
      r_rct_ref      <= '0;
      r_have_ref     <= 1'b0;
      r_su_cnt       <= '0;
      r_rct_fail     <= 1'b0;
      r_apt_fail     <= 1'b0;
      r_startup_done <= 1'b0;
    end else if (w_accept) begin
      r_run      <= w_run_next;
      r_rct_ref  <= sample_in;
      r_have_ref <= 1'b1;
      if (r_state == ST_STARTUP) begin
        r_su_cnt <= w_su_next;
      end
      if (w_rct_hit) begin
        r_rct_fail <= 1'b1;
      end
      if (w_apt_hit) begin
        r_apt_fail <= 1'b1;
      end
      if ((r_state == ST_STARTUP) && (w_state_next == ST_RUN)) begin
        r_startup_done <= 1'b1;
      end
    end
  end

  assign rct_fail     = r_rct_fail;
  assign apt_fail     = r_apt_fail;
  assign startup_done = r_startup_done;
  assign health_ok    = (r_state == ST_RUN);

`ifdef HT_STATS_EN
  logic [7:0] r_max_run;
  logic [7:0] w_run_ext;

  assign w_run_ext = 8'(w_run_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_run <= '0;
    end else if (fail_clr) begin
      r_max_run <= '0;
    end else if (w_accept && (w_run_ext > r_max_run)) begin
      r_max_run <= w_run_ext;
    end
  end

  assign max_run = r_max_run;
`else
  assign max_run = '0;
`endif

endmodule

// File: tb/tb_trng_health_monitor.sv
// Scoreboard bench for trng_health_monitor: stimulus queues expected outputs,
// a monitor pops and compares them after each clock edge.
module tb_trng_health_monitor;

`ifdef HT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       fail_clr = 1'b0;
  logic       rct_fail;
  logic       apt_fail;
  logic       health_ok;
  logic       startup_done;
  logic [7:0] max_run;

  trng_health_monitor #(
    .SYM_W           (1),
    .RCT_CUTOFF      (10),
    .APT_WINDOW      (16),
    .APT_CUTOFF      (12),
    .STARTUP_SAMPLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .fail_clr     (fail_clr),
    .rct_fail     (rct_fail),
    .apt_fail     (apt_fail),
    .health_ok    (health_ok),
    .startup_done (startup_done),
    .max_run      (max_run)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  flags;
    logic [7:0]  mr;
    bit          mr_chk;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic       e_rct, e_apt, e_ok, e_done;
  logic [7:0] e_mr;
  bit         mr_on;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string nm, input logic [3:0] af, input logic [3:0] ef,
                         input logic [7:0] am, input logic [7:0] em, input bit mchk);
    n_checks++;
    if ((af !== ef) || (mchk && (am !== em))) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: rct/apt/ok/done=%b max_run=%0d, expected %b max_run=%0d",
               nm, cyc, af, am, ef, em);
    end
  endtask

  task automatic set_exp(input logic r, input logic a, input logic o, input logic d);
    e_rct = r; e_apt = a; e_ok = o; e_done = d;
  endtask

  task automatic step(input logic v, input logic s, input logic clr, input string nm);
    exp_t e;
    @(negedge clk);
    sample_valid = v;
    sample_in    = s;
    fail_clr     = clr;
    e.name   = nm;
    e.flags  = {e_rct, e_apt, e_ok, e_done};
    e.mr     = STATS ? e_mr : 8'd0;
    e.mr_chk = !STATS || mr_on;
    e.due    = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: compares every queued expectation that has come due.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while ((sb.size() > 0) && (sb[0].due <= cyc)) begin
        exp_t e;
        e = sb.pop_front();
        compare(e.name, {rct_fail, apt_fail, health_ok, startup_done}, e.flags,
                max_run, e.mr, e.mr_chk);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       run_s [13];
    logic [7:0] run_m [13];
    run_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    run_m = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd7, 8'd7, 8'd7};

    set_exp(0, 0, 0, 0);
    e_mr  = 8'd0;
    mr_on = 1'b0;

    step(0, 0, 0, "reset");
    step(0, 0, 0, "reset");
    @(negedge clk);
    rst = 1'b0;

    // Nine identical samples then a different one: no RCT alarm.
    for (int i = 0; i < 9; i++) step(1, 1, 0, "rct_run9");
    step(1, 0, 0, "rct_run9_break");
    step(0, 0, 1, "clear1");

    // Startup with idle gaps: health_ok only after the 16th valid sample.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) set_exp(0, 0, 1, 1);
      step(1, (i % 2 == 0) ? 1'b1 : 1'b0, 0, "startup_sample");
      step(0, 0, 0, "startup_idle");
    end

    // Ten identical samples in RUN: RCT alarm, health_ok drops.
    for (int i = 0; i < 10; i++) begin
      if (i == 9) set_exp(1, 0, 0, 1);
      step(1, 1, 0, "rct_run10");
    end
    step(0, 0, 0, "failed_hold");

    // FAILED ignores samples; clear with a sample discards that sample.
    for (int i = 0; i < 50; i++) step(1, 1, 0, "failed_ignore");
    set_exp(0, 0, 0, 0);
    step(1, 1, 1, "clr_with_sample");
    for (int i = 0; i < 64; i++) begin
      if (i == 15) set_exp(0, 0, 1, 1);
      step(1, (i % 4 < 2) ? 1'b1 : 1'b0, 0, "apt_1100");
    end

    // Longest-run statistic for runs of 3, 7, 2.
    set_exp(0, 0, 0, 0);
    e_mr  = 8'd0;
    mr_on = 1'b1;
    step(0, 0, 1, "clear_stats");
    for (int i = 0; i < 13; i++) begin
      e_mr = run_m[i];
      step(1, run_s[i], 0, "max_run");
    end
    step(0, 0, 0, "max_run_hold");
    mr_on = 1'b0;

    // Back to RUN, 7 samples into a window, then asynchronous reset.
    set_exp(0, 0, 0, 0);
    step(0, 0, 1, "clear3");
    for (int i = 0; i < 16; i++) begin
      if (i == 15) set_exp(0, 0, 1, 1);
      step(1, (i % 4 < 2) ? 1'b1 : 1'b0, 0, "run_again");
    end
    for (int i = 0; i < 7; i++) step(1, 1, 0, "window_partial");
    @(negedge clk);
    sample_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    compare("async_rst", {rct_fail, apt_fail, health_ok, startup_done}, 4'b0000,
            max_run, 8'd0, 1'b1);
    set_exp(0, 0, 0, 0);
    step(0, 0, 0, "rst_hold");
    rst = 1'b0;

    // Fresh window of 1101: 12th match on the 16th sample, which is also the
    // last startup sample, so FAILED wins and startup_done stays low.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) set_exp(0, 1, 0, 0);
      step(1, (i % 4 != 2) ? 1'b1 : 1'b0, 0, "apt_1101");
    end
    step(0, 0, 0, "apt_fail_hold");

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_health_monitor.md
Name: trng_health_monitor

Overview:
- Parametrised SP 800-90B continuous health-test block for the TRNG raw-noise path.
- Accepts SYM_W-bit samples under a valid strobe and runs the Repetition Count Test (RCT) and Adaptive Proportion Test (APT) in parallel.
- A startup/run/failed state machine gates the health_ok qualifier consumed by the conditioner. Sits between the noise-source sampler and the conditioning stage.

Parameters:
- SYM_W, 1, sample width in bits (1..8)
- RCT_CUTOFF, 10, RCT fails when the current run length reaches this value (range 2..255)
- APT_WINDOW, 1024, APT window length in samples (power of two, 16..4096)
- APT_CUTOFF, 589, APT fails when the reference-symbol count in the window reaches this value (must be <= APT_WINDOW)
- STARTUP_SAMPLES, 1024, valid samples that must pass before health_ok asserts (must be >= 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- sample_in  in  SYM_W  raw noise sample
- sample_valid  in  1  sample_in is consumed this cycle
- fail_clr  in  1  single-cycle pulse; clears alarms and restarts startup
- rct_fail  out  1  sticky RCT alarm
- apt_fail  out  1  sticky APT alarm
- health_ok  out  1  high only in RUN state
- startup_done  out  1  high once STARTUP has completed since the last rst/fail_clr
- max_run  out  8  longest RCT run since the last clear (HT_STATS_EN only)

Behaviour:
- Reset (rst or fail_clr): every output 0; state STARTUP; run counter 0; APT counters 0; no reference symbol held.
- Counter widths: run counter $clog2(RCT_CUTOFF+1), saturating. APT sample and match counters $clog2(APT_WINDOW+1).
- Only cycles with sample_valid=1 advance any counter. Idle cycles hold all state.
- RCT:
  - First valid sample after a clear: run=1, ref=sample.
  - Equal sample: run=run+1, saturating.
  - Different sample: run=1, ref=sample.
  - When the updated run value is >= RCT_CUTOFF, rct_fail is registered high on the same edge, so it is visible the cycle after the RCT_CUTOFF-th identical sample.
- APT:
  - The first valid sample of a window becomes aptref; set cnt=1 and match=1.
  - Each subsequent valid sample: cnt++, and match++ if the sample equals aptref.
  - When the updated match value is >= APT_CUTOFF, apt_fail rises on the same edge.
  - After the sample with cnt==APT_WINDOW, the window closes. The next valid sample starts a new window.
- FSM states: STARTUP, RUN, FAILED.
  - STARTUP -> RUN after STARTUP_SAMPLES valid samples with no alarm. startup_done and health_ok rise on the edge that accepts the last startup sample.
  - STARTUP or RUN -> FAILED on the edge any alarm sets. health_ok falls on that same edge.
  - FAILED: samples are ignored, counters and alarms are frozen, exit only via fail_clr or rst.
  - fail_clr in any state -> STARTUP with full clear.
- Simultaneous events:
  - fail_clr together with sample_valid: the clear wins and the sample is discarded.
  - An RCT and APT failure on the same sample set both alarms.
  - A failure on the last startup sample goes to FAILED; startup_done stays 0.
- rst mid-window or mid-run: all progress is discarded, with no partial-window carry-over.

Optional Feature:
- HT_STATS_EN defined:
  - An 8-bit saturating max_run register is updated whenever run exceeds it.
  - max_run is cleared by rst and fail_clr, and frozen in FAILED.
- HT_STATS_EN undefined: max_run is tied to 0 and no register is inferred.

Decomposition:
- Package trng_ht_pkg holds the state enum (STARTUP/RUN/FAILED) and a clog2-based width constant function.
- Sub-module trng_ht_apt_window implements the APT window counter and comparator. The RCT and FSM remain in the top module.

Test Plan:
- SYM_W=1, RCT_CUTOFF=10:
  - 9 consecutive 1s then a 0 -> rct_fail stays 0.
  - 10 consecutive 1s -> rct_fail=1 the cycle after the 10th sample; health_ok=0; state FAILED.
- STARTUP_SAMPLES=16, alternating 0101… with gaps in sample_valid -> health_ok and startup_done rise exactly after the 16th valid sample, not on idle cycles.
- APT_WINDOW=16, APT_CUTOFF=12, pattern 1101 repeated:
  - The first window reaches 12 matches at the 16th sample -> apt_fail=1.
  - With pattern 1100 repeated, 8 matches per window -> no alarm across 4 windows.
- In FAILED, apply 50 samples, then pulse fail_clr together with sample_valid=1 -> alarms clear, that sample is ignored, and startup restarts from count 0.
- Assert rst mid-window after 7 samples -> all outputs are 0 asynchronously, and the next window starts fresh at cnt=1.
- HT_STATS_EN defined, runs of lengths 3, 7, 2 -> max_run=7. HT_STATS_EN undefined -> max_run=0 throughout.
